// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bundle between the VGA timing core / pattern controls and the
// test-pattern generator; the generator is the slave, the upstream logic the master.
interface vga_pattern_gen_if;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hsync_pol;
    logic        vsync_pol;
    logic [1:0]  pattern_sel;
    logic [23:0] fill_rgb;
    logic [15:0] bar_width;
    logic [7:0]  rgb_red;
    logic [7:0]  rgb_green;
    logic [7:0]  rgb_blue;
    logic        de_out;
    logic        hsync_out;
    logic        vsync_out;

    modport master (
        output de_in, hsync_in, vsync_in, hsync_pol, vsync_pol,
        output pattern_sel, fill_rgb, bar_width,
        input  rgb_red, rgb_green, rgb_blue, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  de_in, hsync_in, vsync_in, hsync_pol, vsync_pol,
        input  pattern_sel, fill_rgb, bar_width,
        output rgb_red, rgb_green, rgb_blue, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source: tracks column/line/frame from the timing core's
// syncs and drives one of four patterns through a two-stage pipeline.
module vga_pattern_gen (
    input  logic             pxl_clk,
    input  logic             pxl_rst,
    vga_pattern_gen_if.slave vif
);

    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pattern_e;

    // Input-cycle state
    logic        vs_prev_q,  vs_prev_d;
    logic        de_prev_q,  de_prev_d;
    logic [15:0] x_cnt_q,    x_cnt_d;
    logic [15:0] y_cnt_q,    y_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0] bar_cnt_q,  bar_cnt_d;
    logic [2:0]  bar_idx_q,  bar_idx_d;
    pattern_e    pat_q,      pat_d;
    logic [23:0] fill_q,     fill_d;

    // Stage 1
    logic        de_s1_q,    de_s1_d;
    logic        hs_s1_q,    hs_s1_d;
    logic        vs_s1_q,    vs_s1_d;
    logic [7:0]  x_s1_q,     x_s1_d;
    logic [7:0]  y_s1_q,     y_s1_d;
    logic [2:0]  bar_s1_q,   bar_s1_d;
    logic [7:0]  frame_s1_q, frame_s1_d;
    pattern_e    pat_s1_q,   pat_s1_d;
    logic [23:0] fill_s1_q,  fill_s1_d;

    // Stage 2
    logic [23:0] rgb_q,      rgb_d;
    logic        de_s2_q,    de_s2_d;
    logic        hs_s2_q,    hs_s2_d;
    logic        vs_s2_q,    vs_s2_d;

    logic        fe;
    logic        le;
    logic [15:0] bw_m1;
    logic        bar_wrap;
    logic [5:0]  chk_sum;
    logic        chk;
    logic [23:0] pix;

    always_comb begin
        fe       = (vif.vsync_in == vif.vsync_pol) && (vs_prev_q != vif.vsync_pol);
        le       = de_prev_q && !vif.de_in;
        bw_m1    = (vif.bar_width == 16'd0) ? 16'd0 : vif.bar_width - 16'd1;
        bar_wrap = (bar_cnt_q == bw_m1);
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        vs_prev_d   = vif.vsync_in;
        de_prev_d   = vif.de_in;
        x_cnt_d     = vif.de_in ? x_cnt_q + 16'd1 : 16'd0;
        y_cnt_d     = y_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pat_d       = pat_q;
        fill_d      = fill_q;
        bar_cnt_d   = 16'd0;
        bar_idx_d   = 3'd0;

        // A frame edge overrides a coincident line end so the new frame starts at line 0.
        if (fe) begin
            y_cnt_d     = 16'd0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            pat_d       = pattern_e'(vif.pattern_sel);
            fill_d      = vif.fill_rgb;
        end else if (le) begin
            y_cnt_d = y_cnt_q + 16'd1;
        end

        if (vif.de_in) begin
            if (bar_wrap) begin
                bar_cnt_d = 16'd0;
                bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + 16'd1;
                bar_idx_d = bar_idx_q;
            end
        end
    end

    // Stage 1 captures the pattern in force for this pixel, so a switch on fe
    // only affects pixels entered after the edge.
    always_comb begin
        de_s1_d    = vif.de_in;
        hs_s1_d    = vif.hsync_in;
        vs_s1_d    = vif.vsync_in;
        x_s1_d     = x_cnt_q[7:0];
        y_s1_d     = y_cnt_q[7:0];
        bar_s1_d   = bar_idx_q;
        frame_s1_d = frame_cnt_q;
        pat_s1_d   = pat_q;
        fill_s1_d  = fill_q;
    end

    always_comb begin
        chk_sum = x_s1_q[5:0] + frame_s1_q[5:0];
        chk     = chk_sum[5] ^ y_s1_q[5];
        pix     = 24'h000000;
        case (pat_s1_q)
            PAT_SOLID:   pix = fill_s1_q;
            PAT_BARS: begin
                case (bar_s1_q)
                    3'd0:    pix = 24'hFFFFFF;
                    3'd1:    pix = 24'hFFFF00;
                    3'd2:    pix = 24'h00FFFF;
                    3'd3:    pix = 24'h00FF00;
                    3'd4:    pix = 24'hFF00FF;
                    3'd5:    pix = 24'hFF0000;
                    3'd6:    pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            PAT_CHECKER: pix = chk ? 24'hFFFFFF : 24'h000000;
            default:     pix = {x_s1_q, y_s1_q, frame_s1_q};
        endcase

        rgb_d   = de_s1_q ? pix : 24'h000000;
        de_s2_d = de_s1_q;
        hs_s2_d = hs_s1_q;
        vs_s2_d = vs_s1_q;
    end

    always_ff @(posedge pxl_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (pxl_rst) begin
            vs_prev_q   <= ~vif.vsync_pol;
            de_prev_q   <= 1'b0;
            x_cnt_q     <= 16'd0;
            y_cnt_q     <= 16'd0;
            frame_cnt_q <= 8'd0;
            bar_cnt_q   <= 16'd0;
            bar_idx_q   <= 3'd0;
            pat_q       <= PAT_SOLID;
            fill_q      <= 24'h000000;
            de_s1_q     <= 1'b0;
            hs_s1_q     <= ~vif.hsync_pol;
            vs_s1_q     <= ~vif.vsync_pol;
            x_s1_q      <= 8'd0;
            y_s1_q      <= 8'd0;
            bar_s1_q    <= 3'd0;
            frame_s1_q  <= 8'd0;
            pat_s1_q    <= PAT_SOLID;
            fill_s1_q   <= 24'h000000;
            rgb_q       <= 24'h000000;
            de_s2_q     <= 1'b0;
            hs_s2_q     <= ~vif.hsync_pol;
            vs_s2_q     <= ~vif.vsync_pol;
        end else begin
            vs_prev_q   <= vs_prev_d;
            de_prev_q   <= de_prev_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            pat_q       <= pat_d;
            fill_q      <= fill_d;
            de_s1_q     <= de_s1_d;
            hs_s1_q     <= hs_s1_d;
            vs_s1_q     <= vs_s1_d;
            x_s1_q      <= x_s1_d;
            y_s1_q      <= y_s1_d;
            bar_s1_q    <= bar_s1_d;
            frame_s1_q  <= frame_s1_d;
            pat_s1_q    <= pat_s1_d;
            fill_s1_q   <= fill_s1_d;
            rgb_q       <= rgb_d;
            de_s2_q     <= de_s2_d;
            hs_s2_q     <= hs_s2_d;
            vs_s2_q     <= vs_s2_d;
        end
    end

    assign vif.rgb_red   = rgb_q[23:16];
    assign vif.rgb_green = rgb_q[15:8];
    assign vif.rgb_blue  = rgb_q[7:0];
    assign vif.de_out    = de_s2_q;
    assign vif.hsync_out = hs_s2_q;
    assign vif.vsync_out = vs_s2_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset, bars, frame-synchronous switch,
// checkerboard scroll, fe/le collision, frame wrap, blanking and mid-frame reset.
module tb_vga_pattern_gen;

    logic pxl_clk = 1'b0;
    logic pxl_rst;

    always #5 pxl_clk = ~pxl_clk;

    vga_pattern_gen_if vif ();

    vga_pattern_gen dut (
        .pxl_clk (pxl_clk),
        .pxl_rst (pxl_rst),
        .vif     (vif)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frame_no;
    logic [23:0] rgb_log[$];
    logic        de_log[$];
    logic        hs_log[$];
    logic        vs_log[$];
    logic [23:0] bars [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Log entry k holds the outputs seen just after the k-th edge since clear_log,
    // so a pixel driven before edge k shows up at entry k+1.
    task automatic tick();
        @(posedge pxl_clk);
        #1;
        rgb_log.push_back({vif.rgb_red, vif.rgb_green, vif.rgb_blue});
        de_log.push_back(vif.de_out);
        hs_log.push_back(vif.hsync_out);
        vs_log.push_back(vif.vsync_out);
    endtask

    task automatic clear_log();
        rgb_log.delete();
        de_log.delete();
        hs_log.delete();
        vs_log.delete();
    endtask

    task automatic frame_edge();
        vif.de_in    = 1'b0;
        vif.vsync_in = 1'b1;
        tick();
        vif.vsync_in = 1'b0;
        tick();
        frame_no = frame_no + 8'd1;
    endtask

    task automatic run_line(input int n);
        vif.de_in = 1'b1;
        repeat (n) tick();
        vif.de_in = 1'b0;
        repeat (4) tick();
    endtask

    function automatic logic [23:0] chk_colour(input int x, input int y, input logic [7:0] f);
        int s;
        s = x + int'(f);
        return (((s >> 5) & 1) ^ ((y >> 5) & 1)) != 0 ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic test_reset();
        vif.hsync_pol   = 1'b0;
        vif.vsync_pol   = 1'b1;
        vif.de_in       = 1'b0;
        vif.hsync_in    = 1'b0;
        vif.vsync_in    = 1'b1;
        vif.pattern_sel = 2'd0;
        vif.fill_rgb    = 24'h0;
        vif.bar_width   = 16'd0;
        pxl_rst         = 1'b1;
        clear_log();
        repeat (4) tick();
        pxl_rst      = 1'b0;
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({rgb_log[i], de_log[i], hs_log[i], vs_log[i]} !== {24'h0, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset[%0d]: rgb=%06h de=%b hs=%b vs=%b, want rgb=000000 de=0 hs=1 vs=0",
                         i, rgb_log[i], de_log[i], hs_log[i], vs_log[i]);
            end
        end
        frame_no = 8'd0;
    endtask

    task automatic test_bars();
        int ones;
        vif.pattern_sel = 2'd1;
        vif.bar_width   = 16'd2;
        frame_edge();
        clear_log();
        run_line(16);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rgb_log[k+1] !== bars[k/2]) begin
                errors++;
                $display("FAIL bars_w2[%0d]: got %06h want %06h", k, rgb_log[k+1], bars[k/2]);
            end
        end
        ones = 0;
        foreach (de_log[i]) if (de_log[i] === 1'b1) ones++;
        checks++;
        if (ones !== 16 || de_log[0] !== 1'b0 || de_log[1] !== 1'b1 || de_log[16] !== 1'b1) begin
            errors++;
            $display("FAIL de_out_window: high %0d cycles (first=%b last=%b), want 16 from entry 1",
                     ones, de_log[1], de_log[16]);
        end

        vif.bar_width = 16'd0;
        clear_log();
        run_line(16);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rgb_log[k+1] !== bars[(k < 7) ? k : 7]) begin
                errors++;
                $display("FAIL bars_w0[%0d]: got %06h want %06h", k, rgb_log[k+1], bars[(k < 7) ? k : 7]);
            end
        end
    endtask

    task automatic test_switch();
        vif.pattern_sel = 2'd0;
        vif.fill_rgb    = 24'h123456;
        frame_edge();
        clear_log();
        vif.de_in = 1'b1;
        repeat (4) tick();
        vif.pattern_sel = 2'd3;
        repeat (4) tick();
        vif.de_in = 1'b0;
        repeat (4) tick();
        run_line(8);
        // Entries 1..8 are the switched line, 13..20 the following line.
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (rgb_log[k+1] !== 24'h123456 || rgb_log[k+13] !== 24'h123456) begin
                errors++;
                $display("FAIL solid_hold[%0d]: got %06h/%06h want 123456", k, rgb_log[k+1], rgb_log[k+13]);
            end
        end
        frame_edge();
        run_line(8);
        run_line(8);
        clear_log();
        run_line(8);
        checks++;
        if (rgb_log[6] !== {8'h05, 8'h02, frame_no}) begin
            errors++;
            $display("FAIL grad_x5_y2: got %06h want %06h", rgb_log[6], {8'h05, 8'h02, frame_no});
        end
        checks++;
        if (rgb_log[1] !== {8'h00, 8'h02, frame_no}) begin
            errors++;
            $display("FAIL grad_x0_y2: got %06h want %06h", rgb_log[1], {8'h00, 8'h02, frame_no});
        end
    endtask

    task automatic test_checker();
        logic [23:0] line0 [0:63];
        vif.pattern_sel = 2'd2;
        frame_edge();
        for (int ln = 0; ln < 33; ln++) begin
            clear_log();
            run_line(64);
            if (ln == 0) for (int x = 0; x < 64; x++) line0[x] = rgb_log[x+1];
        end
        for (int x = 30; x < 34; x++) begin
            checks++;
            if (line0[x] !== chk_colour(x, 0, frame_no)) begin
                errors++;
                $display("FAIL chk_f%0d_l0_x%0d: got %06h want %06h", frame_no, x, line0[x], chk_colour(x, 0, frame_no));
            end
            checks++;
            if (rgb_log[x+1] !== ~line0[x] || rgb_log[x+1] !== chk_colour(x, 32, frame_no)) begin
                errors++;
                $display("FAIL chk_l32_x%0d: got %06h want %06h", x, rgb_log[x+1], chk_colour(x, 32, frame_no));
            end
        end
        frame_edge();
        clear_log();
        run_line(64);
        for (int x = 30; x < 34; x++) begin
            checks++;
            if (rgb_log[x+1] !== chk_colour(x, 0, frame_no)) begin
                errors++;
                $display("FAIL chk_scroll_f%0d_x%0d: got %06h want %06h", frame_no, x, rgb_log[x+1], chk_colour(x, 0, frame_no));
            end
        end
    endtask

    task automatic test_fe_le();
        vif.pattern_sel = 2'd3;
        frame_edge();
        run_line(8);
        run_line(8);
        vif.de_in = 1'b1;
        repeat (8) tick();
        vif.de_in    = 1'b0;
        vif.vsync_in = 1'b1;
        tick();
        vif.vsync_in = 1'b0;
        frame_no     = frame_no + 8'd1;
        repeat (3) tick();
        clear_log();
        run_line(8);
        checks++;
        if (rgb_log[1] !== {8'h00, 8'h00, frame_no} || rgb_log[4] !== {8'h03, 8'h00, frame_no}) begin
            errors++;
            $display("FAIL fe_le_clear: got %06h,%06h want %06h,%06h",
                     rgb_log[1], rgb_log[4], {8'h00, 8'h00, frame_no}, {8'h03, 8'h00, frame_no});
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            frame_edge();
            clear_log();
            run_line(2);
            checks++;
            if (rgb_log[1] !== {16'h0000, frame_no}) begin
                errors++;
                $display("FAIL frame_wrap[%0d]: got %06h want %06h", i, rgb_log[1], {16'h0000, frame_no});
            end
        end
    endtask

    task automatic test_blank();
        logic [11:0] hs_vec = 12'b1011_0011_1000;
        logic [11:0] vs_vec = 12'b0110_1000_1101;
        vif.pattern_sel = 2'd0;
        vif.fill_rgb    = 24'hFFFFFF;
        frame_edge();
        clear_log();
        for (int i = 0; i < 12; i++) begin
            vif.hsync_in = hs_vec[i];
            vif.vsync_in = vs_vec[i];
            tick();
        end
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (rgb_log[i+1] !== 24'h0 || de_log[i+1] !== 1'b0 ||
                hs_log[i+1] !== hs_vec[i] || vs_log[i+1] !== vs_vec[i]) begin
                errors++;
                $display("FAIL blank[%0d]: rgb=%06h de=%b hs=%b vs=%b, want 000000 0 %b %b",
                         i, rgb_log[i+1], de_log[i+1], hs_log[i+1], vs_log[i+1], hs_vec[i], vs_vec[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        vif.pattern_sel = 2'd3;
        frame_edge();
        vif.de_in = 1'b1;
        repeat (5) tick();
        pxl_rst = 1'b1;
        clear_log();
        tick();
        checks++;
        if ({rgb_log[0], de_log[0], hs_log[0], vs_log[0]} !== {24'h0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: rgb=%06h de=%b hs=%b vs=%b, want 000000 0 1 0",
                     rgb_log[0], de_log[0], hs_log[0], vs_log[0]);
        end
        pxl_rst  = 1'b0;
        frame_no = 8'd0;
        clear_log();
        repeat (5) tick();
        vif.de_in = 1'b0;
        repeat (4) tick();
        checks++;
        if (de_log[2] !== 1'b1 || rgb_log[2] !== 24'h0) begin
            errors++;
            $display("FAIL post_reset_solid: de=%b rgb=%06h, want de=1 rgb=000000", de_log[2], rgb_log[2]);
        end
        frame_edge();
        clear_log();
        run_line(4);
        checks++;
        if (rgb_log[2] !== {8'h01, 8'h00, frame_no} || frame_no !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_frame: got %06h want 010001", rgb_log[2]);
        end
    endtask

    initial begin
        frame_no = 8'd0;
        test_reset();
        test_bars();
        test_switch();
        test_checker();
        test_fe_le();
        test_wrap();
        test_blank();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
